// File: rtl/ring_arb_pkg.sv
// Shared types and one-hot helpers for ring-scheduled arbitration blocks.
// Helpers operate on MAX_N-wide vectors so any requester count up to MAX_N can reuse them.
package ring_arb_pkg;

    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Right shift of a one-hot vector of width n, bit 0 wrapping to bit n-1.
    function automatic logic [MAX_N-1:0] rotr_onehot(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[n-1] = 1'b1;
        end
        return r;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational ring pick: first set req bit scanning downward from the ptr position,
// wrapping from bit 0 to bit N-1.
module ring_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] win,
    output logic         valid
);

    logic [N-1:0] at_or_below;
    logic [N-1:0] masked;
    logic [N-1:0] scan_src;

    // (ptr << 1) - 1 covers bits 0..ptr; for ptr at the top bit the shift overflows to all ones.
    assign at_or_below = (ptr << 1) - N'(1);
    assign masked      = req & at_or_below;
    assign scan_src    = (|masked) ? masked : req;
    assign valid       = |req;

    always_comb begin
        win = '0;
        for (int j = 0; j < N; j++) begin
            if (scan_src[j]) begin
                win    = '0;
                win[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer and bounded grant bursts.
// Grant, index and busy are registered together; req never reaches gnt combinationally.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output state_e               dbg_state
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_e          state_q;
    logic [N-1:0]    ptr_q;
    logic [N-1:0]    gnt_q;
    logic [IW-1:0]   gnt_id_q;
    logic            busy_q;
    logic [HW-1:0]   hold_q;

    logic            owner_req;
    logic            release_now;
    logic [N-1:0]    ptr_d;
    logic [N-1:0]    pick_ptr;
    logic [N-1:0]    win;
    logic            win_valid;
    logic [IW-1:0]   win_id;

    assign owner_req   = |(req & gnt_q);
    assign release_now = (state_q == GRANT) && (!owner_req || hold_q == HW'(MAX_HOLD));
    assign ptr_d       = N'(rotr_onehot(MAX_N'(gnt_q), N));

    // On a release edge the pick already sees the rotated pointer, so the handover has no gap.
    assign pick_ptr    = release_now ? ptr_d : ptr_q;
    assign win_id      = IW'(onehot_to_idx(MAX_N'(win)));

    ring_rr_pick #(
        .N(N)
    ) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .win  (win),
        .valid(win_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= {1'b1, {(N-1){1'b0}}};
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q  <= GRANT;
                        gnt_q    <= win;
                        gnt_id_q <= win_id;
                        busy_q   <= 1'b1;
                        hold_q   <= HW'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_q <= ptr_d;
                        if (win_valid) begin
                            gnt_q    <= win;
                            gnt_id_q <= win_id;
                            busy_q   <= 1'b1;
                            hold_q   <= HW'(1);
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            hold_q  <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter (N=4, MAX_HOLD=4): directed scenarios plus randomized traffic
// checked against an index-based round-robin model.
module tb_ring_rr_arbiter;
    import ring_arb_pkg::*;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    state_e       dbg_state;

    int n_vec;
    int n_err;

    // Reference model: indices and counts, not one-hot registers.
    int m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_gnt_id;

    ring_rr_arbiter #(
        .N       (N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p - k + N) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = m_busy ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_gnt_id), m_busy[0], m_busy[0]};
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_owner  = 0;
        m_ptr    = N - 1;
        m_hold   = 0;
        m_gnt_id = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int w;
        if (m_busy == 0) begin
            w = m_pick(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_gnt_id = w; m_hold = 1;
            end
        end else if (!r[m_owner] || m_hold == MAX_HOLD) begin
            m_ptr = (m_owner + N - 1) % N;
            w = m_pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_gnt_id = w; m_hold = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_hold++;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs settled.
    task automatic tick(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    function automatic logic [7:0] observed();
        return {gnt, gnt_id, busy, dbg_state == GRANT};
    endfunction

    task automatic test_reset();
        logic [7:0] exp_v;
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        #2;
        exp_v = {4'b0000, 2'd0, 1'b0, 1'b0};
        n_vec++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL reset_state got=%b want=%b", observed(), exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b0000);
        n_vec++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL reset_idle_no_req got=%b want=%b", observed(), exp_v);
        end
    endtask

    task automatic test_full_rotation();
        int e_idx;
        logic [7:0] exp_v;
        for (int c = 0; c < 20; c++) begin
            tick(4'b1111);
            e_idx = 3 - ((c / 4) % 4);
            exp_v = {4'(1 << e_idx), 2'(e_idx), 1'b1, 1'b1};
            n_vec++;
            if (observed() !== exp_v) begin
                n_err++;
                $display("FAIL rotation cycle=%0d got=%b want=%b", c, observed(), exp_v);
            end
            n_vec++;
            if (observed() !== model_out()) begin
                n_err++;
                $display("FAIL rotation_model cycle=%0d got=%b want=%b", c, observed(), model_out());
            end
        end
        tick(4'b0000);
        n_vec++;
        if (observed() !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rotation_release got=%b want=%b", observed(), {4'b0000, 2'd3, 1'b0, 1'b0});
        end
    endtask

    task automatic test_idle_return();
        for (int c = 0; c < 2; c++) begin
            tick(4'b0001);
            n_vec++;
            if (observed() !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL idle_return_grant cycle=%0d got=%b want=%b", c, observed(), {4'b0001, 2'd0, 1'b1, 1'b1});
            end
        end
        tick(4'b0000);
        n_vec++;
        if (observed() !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL idle_return_drop got=%b want=%b", observed(), {4'b0000, 2'd0, 1'b0, 1'b0});
        end
        tick(4'b1001);
        n_vec++;
        if (observed() !== {4'b1000, 2'd3, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL idle_return_wrap got=%b want=%b", observed(), {4'b1000, 2'd3, 1'b1, 1'b1});
        end
        tick(4'b0000);
    endtask

    task automatic test_sole_hold();
        for (int c = 0; c < 10; c++) begin
            tick(4'b0100);
            n_vec++;
            if (observed() !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL sole_hold cycle=%0d got=%b want=%b", c, observed(), {4'b0100, 2'd2, 1'b1, 1'b1});
            end
        end
        tick(4'b0000);
    endtask

    task automatic test_no_preempt();
        tick(4'b0010);
        n_vec++;
        if (observed() !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL no_preempt_first got=%b want=%b", observed(), {4'b0010, 2'd1, 1'b1, 1'b1});
        end
        for (int c = 0; c < 2; c++) begin
            tick(4'b1010);
            n_vec++;
            if (observed() !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL no_preempt_hold cycle=%0d got=%b want=%b", c, observed(), {4'b0010, 2'd1, 1'b1, 1'b1});
            end
        end
        tick(4'b1000);
        n_vec++;
        if (observed() !== {4'b1000, 2'd3, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL no_preempt_handover got=%b want=%b", observed(), {4'b1000, 2'd3, 1'b1, 1'b1});
        end
        tick(4'b0000);
    endtask

    task automatic test_async_reset();
        tick(4'b0100);
        n_vec++;
        if (observed() !== model_out()) begin
            n_err++;
            $display("FAIL async_pre_grant got=%b want=%b", observed(), model_out());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (observed() !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_clear got=%b want=%b", observed(), {4'b0000, 2'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b0011);
        n_vec++;
        if (observed() !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL async_after_release got=%b want=%b", observed(), {4'b0010, 2'd1, 1'b1, 1'b1});
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 4'($urandom_range(0, 15));
            end
            tick(r);
            n_vec++;
            if (observed() !== model_out()) begin
                n_err++;
                $display("FAIL random cycle=%0d req=%b got=%b want=%b", c, r, observed(), model_out());
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;
        test_reset();
        test_full_rotation();
        test_idle_return();
        test_sole_hold();
        test_no_preempt();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
